sub_mod_seq: RTL and testbench

Sequential limb-serial modular subtractor: returns (opA − opB) mod opM for DATA_WIDTH-bit operands, processing LIMB_WIDTH bits per cycle with a valid/ready handshake on both sides. It is the inverse-direction companion of the combinational modular adder in the modular arithmetic library. ECC point-arithmetic datapaths use it where area matters more than latency.

---
 rtl/sub_mod_pkg.sv | 19 +
 rtl/sub_mod_seq_if.sv | 40 ++++
 rtl/limb_addsub.sv | 36 +++
 rtl/sub_mod_seq.sv | 161 ++++++++++++++++
 tb/tb_sub_mod_seq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sub_mod_pkg.sv
// Shared types and constants for the limb-serial modular subtractor.
// Imported by the interface, the limb adder/subtractor and the top.
package sub_mod_pkg;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_LIMB_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        ADD,
        DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_mod_seq_if.sv
// Operand/result handshake bundle for sub_mod_seq.
// master drives operands and out_ready, slave is the subtractor.
interface sub_mod_seq_if
    import sub_mod_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] opA;
    logic [DATA_WIDTH-1:0] opB;
    logic [DATA_WIDTH-1:0] opM;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output opA,
        output opB,
        output opM,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  opA,
        input  opB,
        input  opM,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/limb_addsub.sv
// One-limb adder/subtractor with carry/borrow in and out.
// Shared by the SUB and ADD phases of sub_mod_seq.
module limb_addsub #(
    parameter int LIMB_WIDTH = 64
) (
    input  logic [LIMB_WIDTH-1:0] a,
    input  logic [LIMB_WIDTH-1:0] b,
    input  logic                  op_sub,
    input  logic                  cin,
    output logic [LIMB_WIDTH-1:0] y,
    output logic                  cout
);

    logic [LIMB_WIDTH:0] r;
    logic [LIMB_WIDTH:0] a_x;
    logic [LIMB_WIDTH:0] b_x;
    logic [LIMB_WIDTH:0] c_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};
    assign c_x = {{LIMB_WIDTH{1'b0}}, cin};

    // Top bit of the widened result is the borrow (sub) or carry (add).
    always_comb begin
        r = '0;
        if (op_sub) begin
            r = a_x - b_x - c_x;
        end else begin
            r = a_x + b_x + c_x;
        end
    end

    assign y    = r[LIMB_WIDTH-1:0];
    assign cout = r[LIMB_WIDTH];

endmodule

// File: rtl/sub_mod_seq.sv
// Limb-serial (opA - opB) mod opM with valid/ready on both sides.
// SUB_MOD_SEQ_CONST_TIME_EN: always run the ADD phase (fixed latency).
module sub_mod_seq
    import sub_mod_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LIMB_WIDTH = DEF_LIMB_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    sub_mod_seq_if.slave  bus
);

    localparam int NUM_LIMBS = DATA_WIDTH / LIMB_WIDTH;
    localparam int CW        = cnt_width(NUM_LIMBS);
    localparam logic [CW-1:0] LAST = CW'(NUM_LIMBS - 1);
    localparam int TOP_SH    = DATA_WIDTH - LIMB_WIDTH;

    generate
        if ((DATA_WIDTH % LIMB_WIDTH) != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of LIMB_WIDTH");
        end
    endgenerate

    state_t                state;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] m_q;
    logic [CW-1:0]         limb_q;
    logic                  cb_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
`ifdef SUB_MOD_SEQ_CONST_TIME_EN
    logic                  neg_q;
`endif

    logic                  op_sub;
    logic [LIMB_WIDTH-1:0] addend;
    logic [LIMB_WIDTH-1:0] limb_y;
    logic                  limb_co;
    logic [DATA_WIDTH-1:0] a_shift;
    logic [DATA_WIDTH-1:0] b_shift;
    logic [DATA_WIDTH-1:0] m_rot;

    assign op_sub = (state == SUB);

    // Select the second limb operand: b in SUB, (masked) m in ADD.
    always_comb begin
        addend = '0;
`ifdef SUB_MOD_SEQ_CONST_TIME_EN
        if (op_sub) begin
            addend = b_q[LIMB_WIDTH-1:0];
        end else begin
            addend = m_q[LIMB_WIDTH-1:0] & {LIMB_WIDTH{neg_q}};
        end
`else
        if (op_sub) begin
            addend = b_q[LIMB_WIDTH-1:0];
        end else begin
            addend = m_q[LIMB_WIDTH-1:0];
        end
`endif
    end

    limb_addsub #(
        .LIMB_WIDTH (LIMB_WIDTH)
    ) u_limb (
        .a      (a_q[LIMB_WIDTH-1:0]),
        .b      (addend),
        .op_sub (op_sub),
        .cin    (cb_q),
        .y      (limb_y),
        .cout   (limb_co)
    );

    // a_q doubles as the result: each new limb enters at the top, so
    // after NUM_LIMBS steps it holds the full value in order.
    assign a_shift = (a_q >> LIMB_WIDTH)
                   | (DATA_WIDTH'(limb_y) << TOP_SH);
    assign b_shift = b_q >> LIMB_WIDTH;
    assign m_rot   = (m_q >> LIMB_WIDTH)
                   | (DATA_WIDTH'(m_q[LIMB_WIDTH-1:0]) << TOP_SH);

    // Control FSM with limb counter, carry/borrow and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            limb_q      <= '0;
            cb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef SUB_MOD_SEQ_CONST_TIME_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.opA;
                        b_q    <= bus.opB;
                        m_q    <= bus.opM;
                        limb_q <= '0;
                        cb_q   <= 1'b0;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    a_q <= a_shift;
                    b_q <= b_shift;
                    if (limb_q == LAST) begin
                        limb_q <= '0;
                        cb_q   <= 1'b0;
`ifdef SUB_MOD_SEQ_CONST_TIME_EN
                        neg_q  <= limb_co;
                        state  <= ADD;
`else
                        if (limb_co) begin
                            state <= ADD;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= a_shift;
                        end
`endif
                    end else begin
                        limb_q <= limb_q + 1'b1;
                        cb_q   <= limb_co;
                    end
                end
                ADD: begin
                    a_q <= a_shift;
                    m_q <= m_rot;
                    if (limb_q == LAST) begin
                        limb_q      <= '0;
                        cb_q        <= 1'b0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= a_shift;
                    end else begin
                        limb_q <= limb_q + 1'b1;
                        cb_q   <= limb_co;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_sub_mod_seq.sv
// Directed self-checking bench for sub_mod_seq.
// Latency expectations follow SUB_MOD_SEQ_CONST_TIME_EN when defined.
module tb_sub_mod_seq;
    import sub_mod_pkg::*;

    localparam int NL = DEF_DATA_WIDTH / DEF_LIMB_WIDTH;
`ifdef SUB_MOD_SEQ_CONST_TIME_EN
    localparam int LAT_NB = 2 * NL;
`else
    localparam int LAT_NB = NL;
`endif
    localparam int LAT_B = 2 * NL;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [255:0] TWO64 = 256'h1_0000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sub_mod_seq_if bus ();

    sub_mod_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [255:0] a,
                          input logic [255:0] b,
                          input logic [255:0] m,
                          input int exp_lat,
                          input logic [255:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'd1);
        bus.in_valid = 1'b1;
        bus.opA      = a;
        bus.opB      = b;
        bus.opM      = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
        chk({tag, "_latency"}, 256'(n), 256'(exp_lat));
        chk({tag, "_data"}, bus.out_data, exp);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ov_low"}, 256'(bus.out_valid), 256'd0);
        chk({tag, "_ir_high"}, 256'(bus.in_ready), 256'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opA       = '0;
        bus.opB       = '0;
        bus.opM       = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(bus.in_ready), 256'd0);
        chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
        chk("rst_out_data", bus.out_data, 256'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 256'(bus.in_ready), 256'd1);

        run_op("10m3", 256'd10, 256'd3, P256, LAT_NB, 256'd7);
        release_out("10m3");

        run_op("3m10", 256'd3, 256'd10, P256, LAT_B, P256 - 256'd7);
        release_out("3m10");

        run_op("limbx", TWO64, 256'd1, P256, LAT_NB, TWO64 - 256'd1);
        release_out("limbx");

        run_op("eq", 256'd5, 256'd5, P256, LAT_NB, 256'd0);
        release_out("eq");

        run_op("carry", 256'd0, P256 - 256'd1, P256, LAT_B, 256'd1);
        release_out("carry");

        run_op("hold", 256'd10, 256'd3, P256, LAT_NB, 256'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.opA      = 256'(i * 11 + 1);
            bus.opB      = 256'(i + 2);
            chk("hold_in_ready", 256'(bus.in_ready), 256'd0);
            chk("hold_out_valid", 256'(bus.out_valid), 256'd1);
            chk("hold_out_data", bus.out_data, 256'd7);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("hold_last_data", bus.out_data, 256'd7);
        release_out("hold");

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opA      = 256'd20;
        bus.opB      = 256'd3;
        bus.opM      = P256;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 256'(bus.in_ready), 256'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 256'(bus.in_ready), 256'd1);
        chk("post_rst_out_valid", 256'(bus.out_valid), 256'd0);
        chk("post_rst_out_data", bus.out_data, 256'd0);
        repeat (NL + 2) @(posedge clk);
        #1;
        chk("post_rst_no_result", 256'(bus.out_valid), 256'd0);

        run_op("after_rst", 256'd10, 256'd3, P256, LAT_NB, 256'd7);
        release_out("after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
